// File: rtl/multi_en_reg_bank.sv
// Bank of NREG enabled WIDTH-bit registers with registered readback, write tracking,
// sticky conflict flag and a full scan chain. Define MULTI_EN_REG_BANK_PARITY_EN for per-register parity.
module multi_en_reg_bank #(
  parameter int WIDTH = 4,
  parameter int NREG  = 16,
  parameter int IDXW  = $clog2(NREG)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d_in,
  input  logic [NREG-1:0]  en,
  input  logic [IDXW-1:0]  rd_sel,
  output logic [WIDTH-1:0] d_out,
  output logic             wr_valid,
  output logic [IDXW-1:0]  last_wr,
  output logic             conflict,
  input  logic             scan_en,
  input  logic             scan_in,
  output logic             scan_out,
  output logic             scan_done
`ifdef MULTI_EN_REG_BANK_PARITY_EN
  ,
  output logic             parity_err
`endif
);

`ifdef MULTI_EN_REG_BANK_PARITY_EN
  localparam int RW = WIDTH + 1;
`else
  localparam int RW = WIDTH;
`endif
  localparam int L  = NREG * RW;
  localparam int CW = $clog2(L);

  // Register i occupies r_chain[i*RW +: RW]; parity (if present) is its top bit.
  logic [L-1:0]     r_chain;
  logic [WIDTH-1:0] r_dout;
  logic             r_wr_valid;
  logic [IDXW-1:0]  r_last_wr;
  logic             r_conflict;
  logic [CW-1:0]    r_cnt;
  logic             r_scan_done;

  logic [WIDTH-1:0] w_rd_data;
  logic [IDXW-1:0]  w_last_idx;
  logic             w_multi;
  logic             w_cnt_wrap;
`ifdef MULTI_EN_REG_BANK_PARITY_EN
  logic             r_perr;
  logic             w_rd_perr;
`endif

  always_comb begin
    w_rd_data = '0;
`ifdef MULTI_EN_REG_BANK_PARITY_EN
    w_rd_perr = 1'b0;
`endif
    for (int i = 0; i < NREG; i++) begin
      if (rd_sel == IDXW'(i)) begin
        w_rd_data = r_chain[i*RW +: WIDTH];
`ifdef MULTI_EN_REG_BANK_PARITY_EN
        w_rd_perr = r_chain[i*RW + WIDTH] ^ (^r_chain[i*RW +: WIDTH]);
`endif
      end
    end
  end

  always_comb begin
    w_last_idx = r_last_wr;
    for (int i = 0; i < NREG; i++) begin
      if (en[i]) w_last_idx = IDXW'(i);
    end
  end

  // More than one bit set iff clearing the lowest set bit leaves something.
  assign w_multi    = |(en & (en - NREG'(1)));
  assign w_cnt_wrap = (r_cnt == CW'(L - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_chain     <= '0;
      r_dout      <= '0;
      r_wr_valid  <= 1'b0;
      r_last_wr   <= '0;
      r_conflict  <= 1'b0;
      r_cnt       <= '0;
      r_scan_done <= 1'b0;
`ifdef MULTI_EN_REG_BANK_PARITY_EN
      r_perr      <= 1'b0;
`endif
    end else if (scan_en) begin
      r_chain     <= {r_chain[L-2:0], scan_in};
      r_wr_valid  <= 1'b0;
      r_scan_done <= w_cnt_wrap;
      r_cnt       <= w_cnt_wrap ? '0 : r_cnt + CW'(1);
    end else begin
      for (int i = 0; i < NREG; i++) begin
        if (en[i]) begin
          r_chain[i*RW +: WIDTH] <= d_in;
`ifdef MULTI_EN_REG_BANK_PARITY_EN
          r_chain[i*RW + WIDTH]  <= ^d_in;
`endif
        end
      end
      r_dout      <= w_rd_data;
      r_wr_valid  <= |en;
      r_last_wr   <= w_last_idx;
      if (w_multi) r_conflict <= 1'b1;
      r_cnt       <= '0;
      r_scan_done <= 1'b0;
`ifdef MULTI_EN_REG_BANK_PARITY_EN
      r_perr      <= w_rd_perr;
`endif
    end
  end

  assign d_out     = r_dout;
  assign wr_valid  = r_wr_valid;
  assign last_wr   = r_last_wr;
  assign conflict  = r_conflict;
  assign scan_out  = r_chain[L-1];
  assign scan_done = r_scan_done;
`ifdef MULTI_EN_REG_BANK_PARITY_EN
  assign parity_err = r_perr;
`endif

endmodule

// File: doc/multi_en_reg_bank.md
Name: multi_en_reg_bank

Overview:
- Parametrised successor to the 4-bit multi-enable data register.
- NREG independent WIDTH-bit registers, each with its own load enable, all sharing one data input.
- Adds registered indexed readback, last-write tracking, a sticky multi-enable conflict flag, and a serial scan chain through every register bit for test access.
- Sits in the register/test-structure area of the design as the generic enabled register store.

Parameters:
- WIDTH, 4, data width of each register (1..32).
- NREG, 16, number of registers (2..64).
- IDXW, $clog2(NREG), width of index ports (derived; not overridden).

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous active-high reset
- d_in  input  WIDTH  write data, shared by all registers
- en  input  NREG  per-register load enables; bit i loads register i
- rd_sel  input  IDXW  readback register index
- d_out  output  WIDTH  registered readback data
- wr_valid  output  1  at least one register loaded last cycle
- last_wr  output  IDXW  highest index loaded last cycle
- conflict  output  1  sticky: two or more enables seen in one functional cycle
- scan_en  input  1  scan shift mode
- scan_in  input  1  serial scan data in
- scan_out  output  1  serial scan data out
- scan_done  output  1  one-cycle pulse when a full chain length has been shifted

Behaviour:
- Reset (rst=1 at clk edge), with priority over everything:
  - all registers 0; d_out=0, wr_valid=0, last_wr=0, conflict=0, scan_done=0; shift counter=0.
  - scan_out=0, since it is taken from the last chain flop.
  - A reset asserted mid-scan aborts the shift; the counter restarts at 0.
- Functional mode (scan_en=0):
  - Every register i with en[i]=1 loads d_in on the edge. Multiple simultaneous loads are legal, and each enabled register gets d_in.
  - Registers with en[i]=0 hold.
- Readback:
  - d_out <= reg[rd_sel], sampling the pre-edge register value; latency is 1 cycle.
  - If the selected register is written in the same cycle, d_out shows the old value; the new value appears one cycle later.
  - rd_sel >= NREG gives d_out <= 0.
- wr_valid <= |en and last_wr <= highest set index of en, only while scan_en=0. If en=0, last_wr holds its previous value.
- conflict is set when popcount(en) >= 2 with scan_en=0. It is cleared only by rst.
- Scan mode (scan_en=1):
  - en is ignored; wr_valid <= 0; d_out holds.
  - Chain order: scan_in -> reg[0] bit0 -> … -> reg[0] bit WIDTH-1 -> reg[1] bit0 -> … -> reg[NREG-1] bit WIDTH-1 -> scan_out. One bit shifts per cycle.
  - Chain length L = NREG*WIDTH (see PARITY_EN).
  - Shift counter counts 0..L-1 while scan_en=1. On the shift that takes it from L-1, it wraps to 0 and scan_done pulses high for one cycle, registered on that same edge.
  - When scan_en=0 the counter is forced to 0, so a partial shift followed by a scan_en drop loses count.
- scan_en and en asserted together: scan wins.

Optional Feature:
- Macro: MULTI_EN_REG_BANK_PARITY_EN.
- Defined:
  - Each register gains one even-parity bit, written as ^d_in on load.
  - The parity bit sits in the chain after its register's data bits, so L = NREG*(WIDTH+1).
  - Extra output port parity_err (1 bit), reset 0, registered with d_out. It is 1 when the stored parity of reg[rd_sel] mismatches ^reg[rd_sel]. Errors can be injected only via scan.
  - rd_sel out of range gives parity_err=0.
- Undefined: no parity storage, no parity_err port, L = NREG*WIDTH.

Test Plan:
1. Reset and readback: rst for 2 cycles -> all outputs 0; write en=16'h0004, d_in=4'hA, then rd_sel=2 -> d_out=4'hA two edges after the write; rd_sel=3 -> d_out=0.
2. Multi-enable: en=16'h8101, d_in=4'h5 -> regs 0, 8, 15 read 4'h5; next cycle wr_valid=1, last_wr=15, conflict=1; conflict stays 1 after en=0 until rst.
3. Same-cycle read/write: reg5=4'h3, then en=bit5, d_in=4'hC, rd_sel=5 -> d_out=4'h3 next cycle, 4'hC the cycle after.
4. Scan wraparound: load reg[i]=i; scan_en=1 with scan_in=0 for 64 cycles -> scan_out produces the bit stream reg15 MSB first … reg0 LSB last; scan_done pulses exactly at cycle 64; all regs 0 afterwards.
5. Scan priority and abort: scan_en=1 with en=all-ones, d_in=4'hF for 10 cycles -> no loads, wr_valid=0, conflict unchanged; rst at cycle 5 -> counter 0 and no scan_done at the original count.
6. Parity (macro defined): scan in a single flipped parity bit for reg7 (L=80), rd_sel=7 -> parity_err=1 next cycle; rewrite reg7 normally -> parity_err=0.
